// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with wrap-bit pointers, registered status flags,
// selectable registered or first-word-fall-through read data, and sticky error flags.
module param_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned FWFT     = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    input  logic                     clr_err_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_acc;
    logic             rd_acc;
    logic [AW-1:0]    head_addr;

    always_comb begin
        wr_acc    = wr_en_i & ~full_q;
        rd_acc    = rd_en_i & ~empty_q;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_acc);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_acc);
        count_d   = wr_ptr_d - rd_ptr_d;
        empty_d   = (wr_ptr_d == rd_ptr_d);
        full_d    = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        af_d      = (count_d >= AF_THR);
        ae_d      = (count_d <= AE_THR);
        // Set takes priority over clear.
        ovf_d     = (ovf_q & ~clr_err_i) | (wr_en_i & full_q);
        udf_d     = (udf_q & ~clr_err_i) | (rd_en_i & empty_q);
        head_addr = rd_ptr_d[AW-1:0];
        dout_d    = dout_q;
        if (FWFT != 0) begin
            // The new head is the word being written when it lands in an empty FIFO.
            if (wr_acc || rd_acc) begin
                if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                    dout_d = din_i;
                end else begin
                    dout_d = mem_q[head_addr];
                end
            end
        end else if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o         = dout_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench: a registered-read and a FWFT instance share stimulus; a queue model
// supplies expected data and flags, and monitors check read data as the DUTs present it.
module tb_param_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic       clr_err;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] count0, count1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl[$];
    logic [7:0] exp0[$];
    bit         ovf_m;
    bit         udf_m;
    logic       fire0;

    param_fifo #(.FWFT(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .din_i(din), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .clr_err_i(clr_err), .dout_o(dout0), .full_o(full0), .empty_o(empty0),
        .almost_full_o(af0), .almost_empty_o(ae0), .count_o(count0),
        .overflow_o(ovf0), .underflow_o(udf0)
    );

    param_fifo #(.FWFT(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .din_i(din), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .clr_err_i(clr_err), .dout_o(dout1), .full_o(full1), .empty_o(empty1),
        .almost_full_o(af1), .almost_empty_o(ae1), .count_o(count1),
        .overflow_o(ovf1), .underflow_o(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Registered-read monitor: data is due one cycle after an accepted read.
    always @(posedge clk) fire0 <= rd_en && !empty0;

    always @(negedge clk) begin
        if (fire0) begin
            if (exp0.size() == 0) begin
                chk("dout0_unexpected", 32'(dout0), 32'hdead);
            end else begin
                chk("dout0", 32'(dout0), 32'(exp0.pop_front()));
            end
        end
        if (!empty1) begin
            if (mdl.size() == 0) begin
                chk("dout1_unexpected", 32'(dout1), 32'hdead);
            end else begin
                chk("dout1_head", 32'(dout1), 32'(mdl[0]));
            end
        end
    end

    task automatic chk_state(input string tag);
        int n;
        n = mdl.size();
        chk({tag, ".count0"}, 32'(count0), 32'(n));
        chk({tag, ".count1"}, 32'(count1), 32'(n));
        chk({tag, ".full0"},  32'(full0),  32'(n == 8));
        chk({tag, ".empty0"}, 32'(empty0), 32'(n == 0));
        chk({tag, ".empty1"}, 32'(empty1), 32'(n == 0));
        chk({tag, ".af0"},    32'(af0),    32'(n >= 7));
        chk({tag, ".ae0"},    32'(ae0),    32'(n <= 1));
        chk({tag, ".ovf0"},   32'(ovf0),   32'(ovf_m));
        chk({tag, ".udf0"},   32'(udf0),   32'(udf_m));
        chk({tag, ".ovf1"},   32'(ovf1),   32'(ovf_m));
    endtask

    // Drive one cycle of requests, update the model at the edge, check flags at negedge.
    task automatic step(input string tag, input bit w, input logic [7:0] d, input bit r,
                        input bit c);
        bit full_m;
        bit empty_m;
        din = d; wr_en = w; rd_en = r; clr_err = c;
        @(posedge clk);
        full_m  = (mdl.size() == 8);
        empty_m = (mdl.size() == 0);
        if (r && !empty_m) exp0.push_back(mdl.pop_front());
        if (w && !full_m) mdl.push_back(d);
        ovf_m = (ovf_m && !c) || (w && full_m);
        udf_m = (udf_m && !c) || (r && empty_m);
        @(negedge clk);
        chk_state(tag);
    endtask

    task automatic idle_inputs();
        din = 8'h00; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_state("reset");
        chk("reset.dout0", 32'(dout0), 32'h0);
        chk("reset.dout1", 32'(dout1), 32'h0);
        chk("reset.full1", 32'(full1), 32'h0);
        chk("reset.ae1",   32'(ae1),   32'h1);
        chk("reset.af1",   32'(af1),   32'h0);
        chk("reset.udf1",  32'(udf1),  32'h0);
        @(negedge clk);

        // Fill to full then drain in order.
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill.count_full", 32'(count0), 32'd8);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain.empty", 32'(empty0), 32'h1);

        // Pointer wrap with occupancy held at 3.
        for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        for (int i = 3; i < 12; i++) begin
            step("wrap", 1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
            chk("wrap.count3", 32'(count0), 32'd3);
        end
        for (int i = 0; i < 3; i++) step("wrap_post", 1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow is sticky; set beats clear.
        step("udf_set", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set.udf1", 32'(udf1), 32'h1);
        step("udf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        step("udf_setclr", 1'b0, 8'h00, 1'b1, 1'b1);
        chk("udf_setclr.udf0", 32'(udf0), 32'h1);
        step("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_clr.udf0", 32'(udf0), 32'h0);

        // Simultaneous read/write at count 4, then at full.
        for (int i = 0; i < 4; i++) step("sim_pre", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("sim", 1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
            chk("sim.count4", 32'(count0), 32'd4);
        end
        for (int i = 0; i < 4; i++) step("sim_fill", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step("sim_full_wr_rd", 1'b1, 8'hEE, 1'b1, 1'b0);
        chk("sim_full.count7", 32'(count0), 32'd7);
        chk("sim_full.ovf", 32'(ovf0), 32'h1);
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step("sim_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // FWFT presents the head without a read request.
        step("fwft_wr", 1'b1, 8'h55, 1'b0, 1'b0);
        chk("fwft.dout1", 32'(dout1), 32'h55);
        chk("fwft.empty1", 32'(empty1), 32'h0);
        step("fwft_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_rd.empty1", 32'(empty1), 32'h1);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) step("ar_pre", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        idle_inputs();
        #1;
        reset = 1'b1;
        #1;
        mdl.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        chk_state("areset");
        chk("areset.dout0", 32'(dout0), 32'h0);
        chk("areset.full1", 32'(full1), 32'h0);
        #1;
        reset = 1'b0;
        step("ar_wr", 1'b1, 8'h77, 1'b0, 1'b0);
        step("ar_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("ar_rd.dout0", 32'(dout0), 32'h77);
        idle_inputs();
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
